// File: rtl/store_rmw_unit.sv
// store_rmw_unit
// Store path between the M-stage store request and a word-only DMEM port.
// SW is issued as a single full-word write. SB and SH are done as a
// read-modify-write: read the word, splice in the byte or half lane, and
// write the whole word back. The pipeline stalls while req_ready is low.
//
// Transaction shapes, with N being the accept edge:
//   SW      : WR in N+1                    -> IDLE in N+2
//   SB/SH   : RD in N+1, WT in N+2, WR N+3 -> IDLE in N+4
//   illegal : ERR in N+1                   -> IDLE in N+2
// All DMEM-facing outputs are registered. Their next values are computed
// alongside the next state.

module store_rmw_unit #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_func3,
    input  logic [31:0]       req_addr,
    input  logic [DWIDTH-1:0] req_data,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_re,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              mem_we,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              busy,
    output logic              misaligned_err
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WT,
        WR,
        ERR
    } state_t;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    state_t state;
    state_t state_next;

    // Request fields kept for the merge step.
    // Only the low half of rs2 is ever needed for a partial store.
    logic        half_q;
    logic        half_next;
    logic [1:0]  offset_q;
    logic [1:0]  offset_next;
    logic [15:0] data_q;
    logic [15:0] data_next;

    logic [AWIDTH-1:0] mem_addr_next;
    logic              mem_re_next;
    logic              mem_we_next;
    logic [DWIDTH-1:0] mem_wdata_next;
    logic              err_next;

    logic              accept;
    logic              req_is_sb;
    logic              req_is_sh;
    logic              req_is_sw;
    logic              req_legal;
    logic [DWIDTH-1:0] merged_word;

    // The word address deliberately drops the upper address bits.
    // They are collected here only so that the drop is explicit.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:AWIDTH+2];

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;

    // Classify the incoming request.
    // SB may target any byte. SH must be half-aligned. SW must be
    // word-aligned. Every other funct3 value is illegal.
    always_comb begin
        req_is_sb = (req_func3 == F3_SB);
        req_is_sh = (req_func3 == F3_SH) && !req_addr[0];
        req_is_sw = (req_func3 == F3_SW) && (req_addr[1:0] == 2'b00);
        req_legal = req_is_sb || req_is_sh || req_is_sw;
    end

    // Splice the latched byte or half into the word returned by DMEM.
    // The lanes that are not written keep the read data.
    always_comb begin
        merged_word = mem_rdata;
        if (half_q) begin
            if (offset_q[1]) begin
                merged_word[31:16] = data_q;
            end else begin
                merged_word[15:0] = data_q;
            end
        end else begin
            case (offset_q)
                2'd0:    merged_word[7:0]   = data_q[7:0];
                2'd1:    merged_word[15:8]  = data_q[7:0];
                2'd2:    merged_word[23:16] = data_q[7:0];
                default: merged_word[31:24] = data_q[7:0];
            endcase
        end
    end

    // Compute the next state and the next value of every registered output.
    // A strobe is high only in the cycle that the state it belongs to is entered.
    always_comb begin
        state_next     = state;
        half_next      = half_q;
        offset_next    = offset_q;
        data_next      = data_q;
        mem_addr_next  = mem_addr;
        mem_wdata_next = mem_wdata;
        mem_re_next    = 1'b0;
        mem_we_next    = 1'b0;
        err_next       = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    half_next   = (req_func3 == F3_SH);
                    offset_next = req_addr[1:0];
                    data_next   = req_data[15:0];
                    if (!req_legal) begin
                        state_next = ERR;
                        err_next   = 1'b1;
                    end else if (req_is_sw) begin
                        state_next     = WR;
                        mem_addr_next  = req_addr[AWIDTH+1:2];
                        mem_wdata_next = req_data;
                        mem_we_next    = 1'b1;
                    end else begin
                        state_next    = RD;
                        mem_addr_next = req_addr[AWIDTH+1:2];
                        mem_re_next   = 1'b1;
                    end
                end
            end
            RD: begin
                state_next = WT;
            end
            WT: begin
                state_next     = WR;
                mem_wdata_next = merged_word;
                mem_we_next    = 1'b1;
            end
            WR: begin
                state_next = IDLE;
            end
            ERR: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers.
    // Reset abandons any in-flight read-modify-write. Strobes clear at once,
    // so a half-finished store never reaches memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            half_q         <= 1'b0;
            offset_q       <= 2'b00;
            data_q         <= 16'h0000;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_re         <= 1'b0;
            mem_we         <= 1'b0;
            misaligned_err <= 1'b0;
        end else begin
            state          <= state_next;
            half_q         <= half_next;
            offset_q       <= offset_next;
            data_q         <= data_next;
            mem_addr       <= mem_addr_next;
            mem_wdata      <= mem_wdata_next;
            mem_re         <= mem_re_next;
            mem_we         <= mem_we_next;
            misaligned_err <= err_next;
        end
    end

endmodule

// File: tb/tb_store_rmw_unit.sv
// Testbench for store_rmw_unit.
// Table of single store requests with hand-computed results, plus
// hand-written sequences for reset mid-RMW and back-to-back requests.
// A small DMEM model returns read data one cycle after mem_re.

module tb_store_rmw_unit;

    localparam int KIND_SW  = 0;
    localparam int KIND_RMW = 1;
    localparam int KIND_ERR = 2;

    typedef struct {
        logic [2:0]  func3;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        int          kind;
        logic [31:0] exp_wdata;
        logic [13:0] exp_addr;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [13:0] mem_addr;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        misaligned_err;

    logic [31:0] rd_value;

    int errors;
    int checks;

    int          re_cnt;
    int          re_first;
    int          we_cnt;
    int          we_first;
    int          err_cnt;
    int          err_first;
    int          rdy_first;
    int          busy_cnt;
    int          overlap_cnt;
    logic [31:0] we_wdata;
    logic [13:0] we_addr;
    logic [13:0] re_addr;

    vec_t vecs[12];

    store_rmw_unit #(
        .DWIDTH(32),
        .AWIDTH(14)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_func3     (req_func3),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .mem_addr      (mem_addr),
        .mem_re        (mem_re),
        .mem_rdata     (mem_rdata),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .busy          (busy),
        .misaligned_err(misaligned_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DMEM model: read data appears one cycle after the read strobe.
    // Otherwise it shows a junk value, so that a mistimed sample is caught.
    always @(posedge clk) begin
        mem_rdata <= mem_re ? rd_value : 32'hBAD0_BAD0;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clearObs();
        re_cnt      = 0;
        re_first    = 0;
        we_cnt      = 0;
        we_first    = 0;
        err_cnt     = 0;
        err_first   = 0;
        rdy_first   = 0;
        busy_cnt    = 0;
        overlap_cnt = 0;
        we_wdata    = 32'h0;
        we_addr     = 14'h0;
        re_addr     = 14'h0;
    endtask

    // Record what the DUT shows in cycle k after the accept edge.
    task automatic sampleCycle(input int k);
        if (mem_re) begin
            re_cnt++;
            if (re_first == 0) re_first = k;
            re_addr = mem_addr;
        end
        if (mem_we) begin
            we_cnt++;
            if (we_first == 0) we_first = k;
            we_wdata = mem_wdata;
            we_addr  = mem_addr;
        end
        if (misaligned_err) begin
            err_cnt++;
            if (err_first == 0) err_first = k;
        end
        if (req_ready && rdy_first == 0) rdy_first = k;
        if (busy) busy_cnt++;
        if (mem_re && mem_we) overlap_cnt++;
    endtask

    // Present one request for a single accept edge, then watch six cycles.
    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        rd_value  = v.rdata;
        req_func3 = v.func3;
        req_addr  = v.addr;
        req_data  = v.data;
        req_valid = 1'b1;
        checkOutput($sformatf("v%0d ready_before_accept", idx), {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        clearObs();
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            sampleCycle(k);
        end
    endtask

    task automatic checkVector(input vec_t v, input int idx);
        int exp_re;
        int exp_we;
        int exp_err;
        int exp_rdy;
        int exp_busy;
        exp_re   = (v.kind == KIND_RMW) ? 1 : 0;
        exp_we   = (v.kind == KIND_ERR) ? 0 : 1;
        exp_err  = (v.kind == KIND_ERR) ? 1 : 0;
        exp_rdy  = (v.kind == KIND_RMW) ? 4 : 2;
        exp_busy = exp_rdy - 1;
        checkOutput($sformatf("v%0d re_count", idx), re_cnt, exp_re);
        checkOutput($sformatf("v%0d we_count", idx), we_cnt, exp_we);
        checkOutput($sformatf("v%0d err_count", idx), err_cnt, exp_err);
        checkOutput($sformatf("v%0d ready_cycle", idx), rdy_first, exp_rdy);
        checkOutput($sformatf("v%0d busy_cycles", idx), busy_cnt, exp_busy);
        checkOutput($sformatf("v%0d re_we_overlap", idx), overlap_cnt, 0);
        if (v.kind == KIND_ERR) begin
            checkOutput($sformatf("v%0d err_cycle", idx), err_first, 1);
        end else begin
            checkOutput($sformatf("v%0d we_cycle", idx), we_first, (v.kind == KIND_RMW) ? 3 : 1);
            checkOutput($sformatf("v%0d wdata", idx), we_wdata, v.exp_wdata);
            checkOutput($sformatf("v%0d we_addr", idx), {18'b0, we_addr}, {18'b0, v.exp_addr});
        end
        if (v.kind == KIND_RMW) begin
            checkOutput($sformatf("v%0d re_cycle", idx), re_first, 1);
            checkOutput($sformatf("v%0d re_addr", idx), {18'b0, re_addr}, {18'b0, v.exp_addr});
        end
    endtask

    initial begin
        logic [6:0] ready_bits;
        logic [6:0] we_bits;
        logic [6:0] re_bits;
        logic [31:0] b2b_wdata[2];
        logic [13:0] b2b_addr[2];
        int          b2b_n;

        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_func3 = 3'b000;
        req_addr  = 32'h0;
        req_data  = 32'h0;
        rd_value  = 32'h0;

        //          func3   addr           data           rdata          kind      exp_wdata      exp_addr
        vecs[0]  = '{3'b010, 32'h0000_1004, 32'hCAFE_F00D, 32'h0,         KIND_SW,  32'hCAFE_F00D, 14'h0401};
        vecs[1]  = '{3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h1122_3344, KIND_RMW, 32'hA522_3344, 14'h0400};
        vecs[2]  = '{3'b000, 32'h0000_1000, 32'h0000_00A5, 32'h1122_3344, KIND_RMW, 32'h1122_33A5, 14'h0400};
        vecs[3]  = '{3'b000, 32'h0000_1001, 32'h0000_00A5, 32'h1122_3344, KIND_RMW, 32'h1122_A544, 14'h0400};
        vecs[4]  = '{3'b000, 32'h0000_1002, 32'h0000_00A5, 32'h1122_3344, KIND_RMW, 32'h11A5_3344, 14'h0400};
        vecs[5]  = '{3'b001, 32'h0000_0002, 32'h1234_BEEF, 32'hDEAD_C0DE, KIND_RMW, 32'hBEEF_C0DE, 14'h0000};
        vecs[6]  = '{3'b001, 32'h0000_0000, 32'h1234_BEEF, 32'hDEAD_C0DE, KIND_RMW, 32'hDEAD_BEEF, 14'h0000};
        vecs[7]  = '{3'b001, 32'h0000_0001, 32'h1234_BEEF, 32'hDEAD_C0DE, KIND_ERR, 32'h0,         14'h0000};
        vecs[8]  = '{3'b010, 32'h0000_0002, 32'h1234_BEEF, 32'hDEAD_C0DE, KIND_ERR, 32'h0,         14'h0000};
        vecs[9]  = '{3'b011, 32'h0000_0000, 32'h1234_BEEF, 32'hDEAD_C0DE, KIND_ERR, 32'h0,         14'h0000};
        vecs[10] = '{3'b000, 32'h0000_0002, 32'hFFFF_FF5A, 32'h0000_0000, KIND_RMW, 32'h005A_0000, 14'h0000};
        vecs[11] = '{3'b010, 32'hFFFF_0008, 32'h0102_0304, 32'h0,         KIND_SW,  32'h0102_0304, 14'h0002};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset mem_re", {31'b0, mem_re}, 32'd0);
        checkOutput("reset mem_we", {31'b0, mem_we}, 32'd0);
        checkOutput("reset misaligned_err", {31'b0, misaligned_err}, 32'd0);
        checkOutput("reset busy", {31'b0, busy}, 32'd0);
        checkOutput("reset req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("reset mem_addr", {18'b0, mem_addr}, 32'd0);
        checkOutput("reset mem_wdata", mem_wdata, 32'd0);

        // Table-driven single requests.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i], i);
            checkVector(vecs[i], i);
        end

        // Reset during the WT cycle of an SB: the write must never appear.
        @(negedge clk);
        rd_value  = 32'h5566_7788;
        req_func3 = 3'b000;
        req_addr  = 32'h0000_0010;
        req_data  = 32'h0000_00EE;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        clearObs();
        sampleCycle(1);
        @(negedge clk);
        sampleCycle(2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_wt mem_re", {31'b0, mem_re}, 32'd0);
        checkOutput("rst_wt mem_we", {31'b0, mem_we}, 32'd0);
        checkOutput("rst_wt misaligned_err", {31'b0, misaligned_err}, 32'd0);
        checkOutput("rst_wt busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_wt req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("rst_wt mem_addr", {18'b0, mem_addr}, 32'd0);
        checkOutput("rst_wt mem_wdata", mem_wdata, 32'd0);
        for (int k = 4; k <= 7; k++) begin
            @(negedge clk);
            sampleCycle(k);
        end
        checkOutput("rst_wt we_count", we_cnt, 0);
        checkOutput("rst_wt re_count", re_cnt, 1);

        // req_valid held high: an SB, then an SW presented while the SB is busy.
        @(negedge clk);
        rd_value  = 32'hAABB_CCDD;
        req_func3 = 3'b000;
        req_addr  = 32'h0000_1001;
        req_data  = 32'h0000_0077;
        req_valid = 1'b1;
        @(posedge clk);
        ready_bits = '0;
        we_bits    = '0;
        re_bits    = '0;
        b2b_n      = 0;
        b2b_wdata[0] = 32'h0;
        b2b_wdata[1] = 32'h0;
        b2b_addr[0]  = 14'h0;
        b2b_addr[1]  = 14'h0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            ready_bits[k-1] = req_ready;
            we_bits[k-1]    = mem_we;
            re_bits[k-1]    = mem_re;
            if (mem_we && b2b_n < 2) begin
                b2b_wdata[b2b_n] = mem_wdata;
                b2b_addr[b2b_n]  = mem_addr;
                b2b_n++;
            end
            if (k == 1) begin
                req_func3 = 3'b010;
                req_addr  = 32'h0000_2008;
                req_data  = 32'h0BAD_F00D;
            end
            if (k == 5) req_valid = 1'b0;
        end
        checkOutput("b2b ready_pattern", {25'b0, ready_bits}, {25'b0, 7'b1101000});
        checkOutput("b2b we_pattern", {25'b0, we_bits}, {25'b0, 7'b0010100});
        checkOutput("b2b re_pattern", {25'b0, re_bits}, {25'b0, 7'b0000001});
        checkOutput("b2b sb_wdata", b2b_wdata[0], 32'hAABB_77DD);
        checkOutput("b2b sb_addr", {18'b0, b2b_addr[0]}, 32'h0000_0400);
        checkOutput("b2b sw_wdata", b2b_wdata[1], 32'h0BAD_F00D);
        checkOutput("b2b sw_addr", {18'b0, b2b_addr[1]}, 32'h0000_0802);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
